// File: rtl/render_sched_if.sv
// ---------------------------------------------------------------------------
// render_sched_if
// Control/handshake bundle between the frame scheduler and its neighbours:
// the game logic (mode, frame requests, error clear) and the draw engines and
// frame memory (start/done handshakes, clear strobe, status).
//
//   auto_mode    1 = self-timed frames, 0 = frame_tick-triggered
//   frame_tick   single-cycle frame request
//   obj_en       per-object enable mask (sampled at frame start)
//   obj_done     per-object completion pulse from the draw engines
//   err_clr      clears the sticky timeout flag
//   clr_req      frame-memory clear strobe
//   obj_start    one-hot start pulse to a draw engine
//   busy         scheduler is inside a frame
//   frame_done   one-cycle end-of-frame pulse
//   cur_obj      index of the object currently issued or awaited
//   frame_cnt    completed frames (wrapping)
//   skip_cnt     frame requests dropped while busy (saturating)
//   timeout_err  sticky watchdog error flag
//
// slave  : the scheduler itself.
// master : the surrounding system (game logic plus draw engines).
// ---------------------------------------------------------------------------
interface render_sched_if #(
   parameter int N_OBJ = 4,
   parameter int IDX_W = 2
) ();
   logic             auto_mode;
   logic             frame_tick;
   logic [N_OBJ-1:0] obj_en;
   logic [N_OBJ-1:0] obj_done;
   logic             err_clr;
   logic             clr_req;
   logic [N_OBJ-1:0] obj_start;
   logic             busy;
   logic             frame_done;
   logic [IDX_W-1:0] cur_obj;
   logic [15:0]      frame_cnt;
   logic [7:0]       skip_cnt;
   logic             timeout_err;

   modport slave (
      input  auto_mode, frame_tick, obj_en, obj_done, err_clr,
      output clr_req, obj_start, busy, frame_done, cur_obj,
             frame_cnt, skip_cnt, timeout_err
   );

   modport master (
      output auto_mode, frame_tick, obj_en, obj_done, err_clr,
      input  clr_req, obj_start, busy, frame_done, cur_obj,
             frame_cnt, skip_cnt, timeout_err
   );
endinterface

// File: rtl/render_sched.sv
// ---------------------------------------------------------------------------
// render_sched
// Frame-level controller: for every display frame it strobes the frame-memory
// clear, then starts each enabled draw engine in ascending index order and
// waits for its done pulse (guarded by a per-object watchdog), and finally
// emits frame_done. Frames start on frame_tick, or in auto mode after an idle
// gap of IDLE_MAX cycles.
//
// Ports:
//   clk_i     system clock, all state on the rising edge
//   rst_ni    asynchronous active-low reset
//   sched_if  render_sched_if.slave bundle (see the interface file)
// ---------------------------------------------------------------------------
module render_sched #(
   parameter int N_OBJ    = 4,
   parameter int IDLE_MAX = 1000,
   parameter int TIMEOUT  = 65535,
   parameter int IDX_W    = 2
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   render_sched_if.slave sched_if
);

   localparam int IDLE_W = (IDLE_MAX < 1) ? 1 : $clog2(IDLE_MAX + 1);
   localparam int WD_W   = (TIMEOUT  < 1) ? 1 : $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLR,
      S_CLR_WAIT,
      S_ISSUE,
      S_WAIT_DONE,
      S_FINISH
   } state_t;

   state_t            state_q, state_d;
   logic [N_OBJ-1:0]  en_q, en_d;
   logic [IDX_W-1:0]  cur_obj_q, cur_obj_d;
   logic [IDLE_W-1:0] idle_q, idle_d;
   logic [WD_W-1:0]   wd_q, wd_d;
   logic [15:0]       frame_cnt_q, frame_cnt_d;
   logic [7:0]        skip_cnt_q, skip_cnt_d;
   logic              timeout_err_q, timeout_err_d;

   logic              first_vld;
   logic [IDX_W-1:0]  first_idx;
   logic              next_vld;
   logic [IDX_W-1:0]  next_idx;
   logic              done_hit;
   logic              wd_expired;
   logic              timeout_set;

   // Lowest enabled object overall, and lowest enabled object above cur_obj.
   // Scanning downwards lets the last hit (the lowest index) win.
   always_comb begin
      first_vld = 1'b0;
      first_idx = '0;
      next_vld  = 1'b0;
      next_idx  = '0;
      for (int i = N_OBJ - 1; i >= 0; i--) begin
         if (en_q[i]) begin
            first_vld = 1'b1;
            first_idx = IDX_W'(i);
         end
         if (en_q[i] && (i > int'(cur_obj_q))) begin
            next_vld = 1'b1;
            next_idx = IDX_W'(i);
         end
      end
   end

   // Only the awaited engine's done bit matters; stray done bits are ignored.
   assign done_hit   = sched_if.obj_done[cur_obj_q];
   assign wd_expired = (wd_q == WD_W'(TIMEOUT));

   always_comb begin
      state_d     = state_q;
      en_d        = en_q;
      cur_obj_d   = cur_obj_q;
      idle_d      = idle_q;
      wd_d        = wd_q;
      frame_cnt_d = frame_cnt_q;
      timeout_set = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (sched_if.auto_mode) begin
               if (idle_q == IDLE_W'(IDLE_MAX)) begin
                  state_d = S_CLR;
                  idle_d  = '0;
                  en_d    = sched_if.obj_en;
               end else begin
                  idle_d = idle_q + IDLE_W'(1);
               end
            end else begin
               // Gap counter only runs while self-timed.
               idle_d = '0;
               if (sched_if.frame_tick) begin
                  state_d = S_CLR;
                  en_d    = sched_if.obj_en;
               end
            end
         end

         S_CLR: state_d = S_CLR_WAIT;

         S_CLR_WAIT: begin
            if (first_vld) begin
               cur_obj_d = first_idx;
               state_d   = S_ISSUE;
            end else begin
               state_d = S_FINISH;
            end
         end

         S_ISSUE: begin
            wd_d    = '0;
            state_d = S_WAIT_DONE;
         end

         S_WAIT_DONE: begin
            if (done_hit || wd_expired) begin
               // A done arriving on the expiry cycle still counts as success.
               timeout_set = !done_hit;
               if (next_vld) begin
                  cur_obj_d = next_idx;
                  state_d   = S_ISSUE;
               end else begin
                  state_d = S_FINISH;
               end
            end else begin
               wd_d = wd_q + WD_W'(1);
            end
         end

         S_FINISH: begin
            frame_cnt_d = frame_cnt_q + 16'd1;
            idle_d      = '0;
            state_d     = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase
   end

   // Requests that arrive mid-frame are dropped and tallied; auto mode
   // ignores frame_tick entirely.
   always_comb begin
      skip_cnt_d = skip_cnt_q;
      if (!sched_if.auto_mode && sched_if.frame_tick &&
          (state_q != S_IDLE) && (skip_cnt_q != 8'hFF)) begin
         skip_cnt_d = skip_cnt_q + 8'd1;
      end
   end

   // Set has priority over clear so a coincident timeout is never lost.
   always_comb begin
      timeout_err_d = timeout_err_q;
      if (timeout_set) begin
         timeout_err_d = 1'b1;
      end else if (sched_if.err_clr) begin
         timeout_err_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= S_IDLE;
         en_q          <= '0;
         cur_obj_q     <= '0;
         idle_q        <= '0;
         wd_q          <= '0;
         frame_cnt_q   <= '0;
         skip_cnt_q    <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         en_q          <= en_d;
         cur_obj_q     <= cur_obj_d;
         idle_q        <= idle_d;
         wd_q          <= wd_d;
         frame_cnt_q   <= frame_cnt_d;
         skip_cnt_q    <= skip_cnt_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   // Outputs decode registered state only, so reset clears them immediately.
   logic [N_OBJ-1:0] start_vec;

   for (genvar gi = 0; gi < N_OBJ; gi++) begin : g_start
      assign start_vec[gi] = (state_q == S_ISSUE) && (cur_obj_q == IDX_W'(gi));
   end

   assign sched_if.clr_req     = (state_q == S_CLR);
   assign sched_if.obj_start   = start_vec;
   assign sched_if.busy        = (state_q != S_IDLE);
   assign sched_if.frame_done  = (state_q == S_FINISH);
   assign sched_if.cur_obj     = cur_obj_q;
   assign sched_if.frame_cnt   = frame_cnt_q;
   assign sched_if.skip_cnt    = skip_cnt_q;
   assign sched_if.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_render_sched.sv
// ---------------------------------------------------------------------------
// tb_render_sched
// Self-checking bench for render_sched. A monitor logs clear/start/done
// events with cycle stamps; an engine responder answers each start after a
// per-object delay (0 = never answers). Expected event timelines come from
// a frame-level timing model: clear one cycle after the request, first start
// three cycles after it, each following start one cycle after the previous
// object's done or watchdog expiry.
// ---------------------------------------------------------------------------
module tb_render_sched;
   localparam int N_OBJ    = 4;
   localparam int IDLE_MAX = 10;
   localparam int TIMEOUT  = 20;
   localparam int IDX_W    = 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   render_sched_if #(.N_OBJ(N_OBJ), .IDX_W(IDX_W)) sif ();

   logic [N_OBJ-1:0] resp_done = '0;
   logic [N_OBJ-1:0] tb_done   = '0;
   assign sif.obj_done = resp_done | tb_done;

   render_sched #(
      .N_OBJ   (N_OBJ),
      .IDLE_MAX(IDLE_MAX),
      .TIMEOUT (TIMEOUT),
      .IDX_W   (IDX_W)
   ) dut (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .sched_if(sif)
   );

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference state
   int exp_frames = 0;
   int exp_skip   = 0;
   bit exp_err    = 1'b0;
   int exp_cyc_q[$];
   int exp_vec_q[$];

   // Observed events
   int clr_q[$];
   int start_cyc_q[$];
   int start_vec_q[$];
   int fd_q[$];

   // Engine responder
   int delay [N_OBJ];
   int due   [N_OBJ];

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (sif.clr_req) clr_q.push_back(cyc);
      if (sif.obj_start != '0) begin
         start_cyc_q.push_back(cyc);
         start_vec_q.push_back(int'(sif.obj_start));
      end
      if (sif.frame_done) fd_q.push_back(cyc);
   end

   always @(negedge clk) begin
      for (int i = 0; i < N_OBJ; i++) begin
         resp_done[i] = 1'b0;
         if (!rst_n) begin
            due[i] = -1;
         end else begin
            if (due[i] == cyc) begin
               resp_done[i] = 1'b1;
               due[i] = -1;
            end
            if (sif.obj_start[i] && delay[i] > 0) due[i] = cyc + delay[i];
         end
      end
   end

   function automatic int sat_inc(input int v);
      return (v < 255) ? v + 1 : 255;
   endfunction

   task automatic clear_logs();
      clr_q.delete();
      start_cyc_q.delete();
      start_vec_q.delete();
      fd_q.delete();
   endtask

   // Frame timing model: k is the cycle in which the request is presented.
   task automatic build_expect(input int k, input logic [N_OBJ-1:0] mask,
                               output int fd, output bit to);
      int t;
      int e;
      exp_cyc_q.delete();
      exp_vec_q.delete();
      t  = k + 3;
      to = 1'b0;
      for (int i = 0; i < N_OBJ; i++) begin
         if (mask[i]) begin
            exp_cyc_q.push_back(t);
            exp_vec_q.push_back(1 << i);
            if (delay[i] == 0) begin
               e  = TIMEOUT + 1;
               to = 1'b1;
            end else begin
               e = delay[i];
            end
            t = t + e + 1;
         end
      end
      fd = t;
   endtask

   // One triggered frame. clr_at is the cycle err_clr is raised (-1 = none);
   // when used it is placed on or before the frame's last timeout cycle.
   task automatic run_frame(input logic [N_OBJ-1:0] mask, input bit skip_mid,
                            input bit skip_fin, input int clr_at);
      int k;
      int fd;
      bit to;
      int n;
      k = cyc;
      build_expect(k, mask, fd, to);
      clear_logs();
      sif.obj_en = mask;
      for (int c = k; c <= fd; c++) begin
         sif.frame_tick = (c == k) || (skip_mid && c == k + 1) || (skip_fin && c == fd);
         sif.err_clr    = (c == clr_at);
         if (c == k + 1) sif.obj_en = ~mask;
         @(negedge clk);
      end
      sif.frame_tick = 1'b0;
      sif.err_clr    = 1'b0;

      exp_frames = (exp_frames + 1) & 16'hFFFF;
      if (skip_mid) exp_skip = sat_inc(exp_skip);
      if (skip_fin) exp_skip = sat_inc(exp_skip);
      if (clr_at >= k && !to) exp_err = 1'b0;
      if (to) exp_err = 1'b1;

      check_eq("clr_count", clr_q.size(), 1);
      if (clr_q.size() > 0) check_eq("clr_cycle", clr_q[0] - k, 1);
      check_eq("start_count", start_cyc_q.size(), exp_cyc_q.size());
      n = (start_cyc_q.size() < exp_cyc_q.size()) ? start_cyc_q.size() : exp_cyc_q.size();
      for (int i = 0; i < n; i++) begin
         check_eq("start_cycle", start_cyc_q[i] - k, exp_cyc_q[i] - k);
         check_eq("start_vec", start_vec_q[i], exp_vec_q[i]);
      end
      check_eq("fd_count", fd_q.size(), 1);
      if (fd_q.size() > 0) check_eq("fd_cycle", fd_q[0] - k, fd - k);
      check_eq("frame_cnt", sif.frame_cnt, exp_frames);
      check_eq("skip_cnt", sif.skip_cnt, exp_skip);
      check_eq("timeout_err", sif.timeout_err, exp_err);
      check_eq("busy_after", sif.busy, 0);
      $display("frame tick@%0d mask=%b starts=%0d done@+%0d frames=%0d skips=%0d err=%0d",
               k, mask, start_cyc_q.size(), fd - k, sif.frame_cnt, sif.skip_cnt, sif.timeout_err);
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_clr_req"}, sif.clr_req, 0);
      check_eq({tag, "_obj_start"}, sif.obj_start, 0);
      check_eq({tag, "_busy"}, sif.busy, 0);
      check_eq({tag, "_frame_done"}, sif.frame_done, 0);
      check_eq({tag, "_cur_obj"}, sif.cur_obj, 0);
      check_eq({tag, "_frame_cnt"}, sif.frame_cnt, 0);
      check_eq({tag, "_skip_cnt"}, sif.skip_cnt, 0);
      check_eq({tag, "_timeout_err"}, sif.timeout_err, 0);
   endtask

   initial begin
      int k;
      int c0;
      int fl;
      int free;
      bit to;
      int trig;
      int exp_clr[$];

      sif.auto_mode  = 1'b0;
      sif.frame_tick = 1'b0;
      sif.obj_en     = '0;
      sif.err_clr    = 1'b0;
      for (int i = 0; i < N_OBJ; i++) begin
         delay[i] = 5;
         due[i]   = -1;
      end

      // Reset state
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Normal frame, all engines answer after 5 cycles
      run_frame(4'b1111, 1'b0, 1'b0, -1);
      // Sparse masks
      run_frame(4'b1010, 1'b0, 1'b0, -1);
      run_frame(4'b0000, 1'b0, 1'b0, -1);

      // Timeout on object 2, err_clr coinciding with the expiry (set wins)
      delay[2] = 0;
      k = cyc;
      run_frame(4'b1111, 1'b0, 1'b0, k + 36);
      if (start_cyc_q.size() >= 4)
         check_eq("timeout_gap", start_cyc_q[3] - start_cyc_q[2], TIMEOUT + 2);
      sif.err_clr = 1'b1;
      @(negedge clk);
      sif.err_clr = 1'b0;
      exp_err = 1'b0;
      check_eq("err_clr", sif.timeout_err, 0);

      // Randomized frames, back-to-back, with dropped requests
      for (int f = 0; f < 10; f++) begin
         for (int i = 0; i < N_OBJ; i++)
            delay[i] = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 8));
         run_frame(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), -1);
      end

      // Skip saturation: request every cycle with an empty mask
      sif.obj_en = '0;
      free = cyc;
      for (int t = 0; t < 400; t++) begin
         sif.frame_tick = 1'b1;
         if (cyc >= free) begin
            free = cyc + 3 + 1;  // CLR, CLR_WAIT, FINISH, then IDLE
            exp_frames = (exp_frames + 1) & 16'hFFFF;
         end else begin
            exp_skip = sat_inc(exp_skip);
         end
         @(negedge clk);
         if (t == 39) begin
            check_eq("skip_mid_frames", sif.frame_cnt, exp_frames);
            check_eq("skip_mid_skips", sif.skip_cnt, exp_skip);
         end
      end
      sif.frame_tick = 1'b0;
      @(negedge clk);
      check_eq("skip_sat_frames", sif.frame_cnt, exp_frames);
      check_eq("skip_sat_skips", sif.skip_cnt, exp_skip);
      $display("skip run frames=%0d skips=%0d", sif.frame_cnt, sif.skip_cnt);

      // Auto mode: frames every IDLE_MAX + frame length + 1 cycles
      for (int i = 0; i < N_OBJ; i++) delay[i] = 1;
      sif.obj_en = 4'b1111;
      build_expect(0, 4'b1111, fl, to);
      clear_logs();
      c0 = cyc;
      sif.auto_mode = 1'b1;
      exp_clr.delete();
      trig = c0 + IDLE_MAX;
      while (trig <= c0 + 79) begin
         exp_clr.push_back(trig + 1);
         exp_frames = (exp_frames + 1) & 16'hFFFF;
         trig = trig + fl + IDLE_MAX + 1;
      end
      for (int t = 0; t < 80; t++) begin
         sif.frame_tick = ($urandom_range(0, 3) == 0);
         @(negedge clk);
      end
      sif.auto_mode  = 1'b0;
      sif.frame_tick = 1'b0;
      repeat (40) @(negedge clk);
      check_eq("auto_clr_count", clr_q.size(), exp_clr.size());
      for (int i = 0; i < exp_clr.size() && i < clr_q.size(); i++)
         check_eq("auto_clr_cycle", clr_q[i] - c0, exp_clr[i] - c0);
      check_eq("auto_frames", sif.frame_cnt, exp_frames);
      check_eq("auto_skips", sif.skip_cnt, exp_skip);
      check_eq("auto_busy", sif.busy, 0);
      $display("auto run clears=%0d frames=%0d", clr_q.size(), sif.frame_cnt);

      // Mid-frame reset while waiting on object 1
      delay[0] = 3; delay[1] = 0; delay[2] = 3; delay[3] = 3;
      sif.obj_en     = 4'b0011;
      sif.frame_tick = 1'b1;
      @(negedge clk);
      sif.frame_tick = 1'b0;
      repeat (11) @(negedge clk);
      check_eq("pre_reset_cur_obj", sif.cur_obj, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check_all_zero("async_reset");
      clear_logs();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      exp_frames = 0;
      exp_skip   = 0;
      exp_err    = 1'b0;
      @(negedge clk);
      tb_done = 4'b0010;
      @(negedge clk);
      tb_done = '0;
      repeat (3) @(negedge clk);
      check_eq("late_done_starts", start_cyc_q.size(), 0);
      check_eq("late_done_busy", sif.busy, 0);
      delay[1] = 3;
      run_frame(4'b0011, 1'b0, 1'b0, -1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   // Hard stop in case the sequence above stalls.
   initial begin
      #2000000;
      $display("FAIL watchdog: got %0d cycles expected completion", cyc);
      n_errors++;
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $fatal(1, "bench timeout");
   end
endmodule

// File: doc/render_sched.md
Name: render_sched

Overview:
- Frame-level controller that sequences the pixel-memory clear and the per-object draw engines (three squares, then the player) for each display frame.
- Starts a frame either on an external frame tick or, in auto mode, after a programmable idle gap.
- Per frame: pulses the frame-memory clear, then issues start/done handshakes to each enabled draw engine in ascending index order, with a per-object watchdog.
- Sits between the top-level game logic and the draw engines/frame memory; replaces the ad-hoc CLR/DRAW/IDLE sequencing inside the drawing path.

Parameters:
N_OBJ, 4, number of draw engines; index 0 is drawn first and N_OBJ-1 last (player).
IDLE_MAX, 1000, idle cycles between frames in auto mode.
TIMEOUT, 65535, max cycles to wait for obj_done before aborting an object.
IDX_W, 2, width of the object index; must satisfy 2^IDX_W >= N_OBJ.

Ports:
clk  in  1  system clock, all state on rising edge.
rst  in  1  asynchronous, active-low reset.
auto_mode  in  1  1 = self-timed frames via IDLE_MAX; 0 = frame_tick-triggered.
frame_tick  in  1  single-cycle frame request pulse.
obj_en  in  N_OBJ  per-object enable mask.
obj_done  in  N_OBJ  per-object completion pulse from the draw engines.
err_clr  in  1  clears timeout_err.
clr_req  out  1  frame-memory clear strobe.
obj_start  out  N_OBJ  one-hot start pulse to a draw engine.
busy  out  1  high in any state other than IDLE.
frame_done  out  1  one-cycle pulse at the end of a frame.
cur_obj  out  IDX_W  index of the object currently issued or awaited.
frame_cnt  out  16  count of completed frames; wraps at 65535 -> 0.
skip_cnt  out  8  count of frame requests dropped while busy; saturates at 255.
timeout_err  out  1  sticky flag, set when any object times out.

Behaviour:
- States: IDLE, CLR, CLR_WAIT, ISSUE, WAIT_DONE, FINISH.
- Outputs are decoded from registered state only:
  - clr_req = (state == CLR).
  - obj_start = (state == ISSUE) ? onehot(cur_obj) : 0.
  - frame_done = (state == FINISH).
- Reset (rst = 0, any time, including mid-frame):
  - state = IDLE; all outputs 0; cur_obj = 0.
  - frame_cnt, skip_cnt, timeout_err, the idle counter and the watchdog counter all = 0.
  - Any object in flight is abandoned; no done is awaited after reset release.
- IDLE:
  - auto_mode = 0: frame_tick = 1 -> CLR.
  - auto_mode = 1: the idle counter increments each cycle; when it equals IDLE_MAX -> CLR and the counter clears. frame_tick is ignored and not counted as a skip.
  - On entry to CLR, obj_en is latched into en_q; changes to obj_en mid-frame have no effect.
- CLR:
  - Exactly one cycle with clr_req = 1, then -> CLR_WAIT.
- CLR_WAIT:
  - One settle cycle.
  - If en_q has any bit set: cur_obj = lowest set index, -> ISSUE.
  - Otherwise -> FINISH.
- ISSUE:
  - One cycle with obj_start[cur_obj] = 1.
  - Watchdog counter cleared; -> WAIT_DONE.
- WAIT_DONE:
  - Only obj_done[cur_obj] is observed; all other done bits are ignored.
  - obj_done is never sampled during the ISSUE cycle itself, so the earliest accepted done is the cycle after obj_start.
  - On obj_done[cur_obj], or when the watchdog reaches TIMEOUT (timeout also sets timeout_err):
    - If a set en_q bit exists above cur_obj: cur_obj = next such index, -> ISSUE.
    - Otherwise -> FINISH.
- FINISH:
  - One cycle; frame_cnt increments; -> IDLE; idle counter cleared.
- Minimum latency, frame_tick sampled at edge k:
  - clr_req high in cycle k+1.
  - First obj_start in cycle k+3.
  - With all objects disabled, frame_done in cycle k+3.
- skip_cnt increments on frame_tick while busy = 1, only when auto_mode = 0; it saturates at 255.
- timeout_err:
  - err_clr = 1 clears it.
  - If a timeout and err_clr occur in the same cycle, set wins.
- Back-to-back frames: a frame_tick during the FINISH cycle counts as a skip; a tick in the following IDLE cycle is accepted.

Test Plan:
- Normal frame: auto_mode = 0, obj_en = 4'b1111. Pulse frame_tick; each engine returns done 5 cycles after its start. Expect clr_req for 1 cycle, then obj_start = 0001, 0010, 0100, 1000 in order, then frame_done; frame_cnt = 1.
- Sparse mask: obj_en = 4'b1010. Expect starts only on indices 1 and 3. With obj_en = 4'b0000, expect frame_done exactly 3 cycles after the tick and no obj_start.
- Timeout: TIMEOUT = 20, object 2 never completes. Expect object 3 started 22 cycles after object 2's start, timeout_err = 1, and the frame still completes. Then assert err_clr -> timeout_err = 0.
- Skip counting: issue 300 frame_ticks while busy. Expect skip_cnt = 255 (saturated) and frame_cnt unaffected by the dropped ticks.
- Auto mode: auto_mode = 1, IDLE_MAX = 10, engines done immediately. Expect clr_req to recur every (10 + frame length + 1) cycles, and frame_tick pulses to have no effect.
- Mid-frame reset: drop rst while in WAIT_DONE on object 1. Expect all outputs 0 immediately (asynchronously) and counters 0. After release, a late obj_done[1] is ignored and the next frame_tick starts a clean frame.
